// File: rtl/readback_collector.sv
// readback_collector: polls a crate responder with a one-cycle read strobe,
// then collects a four-word frame from it: header, crate number, status high
// byte, status low byte. The frame is checked as it arrives, and the result
// is reported with a single done pulse plus outcome flags.
module readback_collector #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk16,
  input  logic        init_n,
  input  logic        req,
  input  logic [4:0]  exp_crate,
  input  logic [9:0]  bytin,
  output logic        rd,
  output logic        busy,
  output logic        done,
  output logic [15:0] status,
  output logic [4:0]  crate_rx,
  output logic        frame_err,
  output logic        crate_err,
  output logic        timeout,
  output logic        err_any
);

  typedef enum logic [2:0] {
    IDLE, STROBE, WAIT_HDR, W_CRATE, W_STHI, W_STLO, FIN
  } state_t;

  localparam logic [9:0] HDR_WORD  = 10'h1FF;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg;
  logic [4:0]  crate_shadow_reg;
  logic [7:0]  sthi_shadow_reg;

  // Decoded events for the current cycle, produced by the next-state logic.
  logic accept;       // poll accepted in IDLE
  logic tag_bad;      // frame word with the wrong tag for its slot
  logic wait_expire;  // no header within the timeout window
  logic stlo_load;    // last frame word is valid; commit status and crate

  // State register.
  always_ff @(posedge clk16 or negedge init_n) begin
    if (!init_n) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state decode and per-cycle frame checks.
  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    tag_bad     = 1'b0;
    wait_expire = 1'b0;
    stlo_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Stray header words are ignored here; only req starts a poll.
        if (req) begin
          state_next = STROBE;
          accept     = 1'b1;
        end
      end
      STROBE: state_next = WAIT_HDR;
      WAIT_HDR: begin
        if (bytin == HDR_WORD) begin
          state_next = W_CRATE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next  = FIN;
          wait_expire = 1'b1;
        end
      end
      W_CRATE: begin
        // Tag 00 plus zero upper data bits; a repeated header fails here.
        if (bytin[9:5] == 5'd0) begin
          state_next = W_STHI;
        end else begin
          state_next = FIN;
          tag_bad    = 1'b1;
        end
      end
      W_STHI: begin
        if (bytin[9:8] == 2'b11) begin
          state_next = W_STLO;
        end else begin
          state_next = FIN;
          tag_bad    = 1'b1;
        end
      end
      W_STLO: begin
        state_next = FIN;
        if (bytin[9:8] == 2'b00) stlo_load = 1'b1;
        else                     tag_bad   = 1'b1;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered handshake outputs derived from the state being entered.
  always_ff @(posedge clk16 or negedge init_n) begin
    if (!init_n) begin
      rd   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      rd   <= (state_next == STROBE);
      busy <= (state_next != IDLE);
      done <= (state_next == FIN);
    end
  end

  // Header wait counter; it is held at zero outside WAIT_HDR, so every
  // entry into WAIT_HDR starts counting from zero.
  always_ff @(posedge clk16 or negedge init_n) begin
    if (!init_n)                   wait_cnt_reg <= 8'd0;
    else if (state_reg == WAIT_HDR) wait_cnt_reg <= wait_cnt_reg + 8'd1;
    else                           wait_cnt_reg <= 8'd0;
  end

  // Shadow capture of crate and status high byte, so a frame that fails
  // later never disturbs the visible status/crate_rx.
  always_ff @(posedge clk16 or negedge init_n) begin
    if (!init_n) begin
      crate_shadow_reg <= 5'd0;
      sthi_shadow_reg  <= 8'd0;
    end else begin
      if (state_reg == W_CRATE) crate_shadow_reg <= bytin[4:0];
      if (state_reg == W_STHI)  sthi_shadow_reg  <= bytin[7:0];
    end
  end

  // Commit of a complete good frame.
  always_ff @(posedge clk16 or negedge init_n) begin
    if (!init_n) begin
      status   <= 16'd0;
      crate_rx <= 5'd0;
    end else if (stlo_load) begin
      status   <= {sthi_shadow_reg, bytin[7:0]};
      crate_rx <= crate_shadow_reg;
    end
  end

  // Outcome flags: cleared when a poll is accepted, then held until the next.
  always_ff @(posedge clk16 or negedge init_n) begin
    if (!init_n) begin
      frame_err <= 1'b0;
      crate_err <= 1'b0;
      timeout   <= 1'b0;
    end else if (accept) begin
      frame_err <= 1'b0;
      crate_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (tag_bad)     frame_err <= 1'b1;
      if (wait_expire) timeout   <= 1'b1;
      if (stlo_load)   crate_err <= (crate_shadow_reg != exp_crate);
    end
  end

  // Alignment and lockup summary of the last good status word.
  assign err_any = |status[15:12];

endmodule

// File: tb/tb_readback_collector.sv
// Directed bench for readback_collector: expected frame outcomes are queued
// when a poll is launched and compared when the done pulse appears.
module tb_readback_collector;

  logic        clk16 = 1'b0;
  logic        init_n;
  logic        req;
  logic [4:0]  exp_crate;
  logic [9:0]  bytin;
  logic        rd, busy, done;
  logic [15:0] status;
  logic [4:0]  crate_rx;
  logic        frame_err, crate_err, timeout, err_any;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int          lat;
    logic [15:0] status;
    logic [4:0]  crate;
    logic        fe;
    logic        ce;
    logic        to;
    logic        ea;
  } exp_t;

  exp_t sb[$];

  readback_collector #(.TIMEOUT_CYC(64)) dut (
    .clk16     (clk16),
    .init_n    (init_n),
    .req       (req),
    .exp_crate (exp_crate),
    .bytin     (bytin),
    .rd        (rd),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .crate_rx  (crate_rx),
    .frame_err (frame_err),
    .crate_err (crate_err),
    .timeout   (timeout),
    .err_any   (err_any)
  );

  always #5 clk16 = ~clk16;

  always @(posedge clk16) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},        rd,        0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_status"},    status,    0);
    check({tag, "_crate_rx"},  crate_rx,  0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_crate_err"}, crate_err, 0);
    check({tag, "_timeout"},   timeout,   0);
    check({tag, "_err_any"},   err_any,   0);
  endtask

  // Launch one poll, feed nw frame words starting the cycle after rd, then
  // wait (bounded) for done and compare against the head of the scoreboard.
  task automatic poll(input string tag, input logic [9:0] w0, input logic [9:0] w1,
                      input logic [9:0] w2, input logic [9:0] w3, input int nw);
    logic [9:0] wv [4];
    int   rd_cyc;
    bit   seen;
    exp_t e;
    wv[0] = w0; wv[1] = w1; wv[2] = w2; wv[3] = w3;
    @(negedge clk16) req = 1'b1;
    @(negedge clk16) req = 1'b0;
    check({tag, "_rd_strobe"}, rd, 1);
    check({tag, "_busy_on"}, busy, 1);
    rd_cyc = cyc;
    for (int k = 0; k < nw; k++) begin
      @(negedge clk16);
      check({tag, "_rd_single"}, rd, 0);
      bytin = wv[k];
    end
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk16);
      bytin = 10'h000;
      if (done === 1'b1) seen = 1'b1;
    end
    e = sb.pop_front();
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, 16'(cyc - rd_cyc), 16'(e.lat));
    check({tag, "_status"}, status, e.status);
    check({tag, "_crate_rx"}, crate_rx, e.crate);
    check({tag, "_frame_err"}, frame_err, e.fe);
    check({tag, "_crate_err"}, crate_err, e.ce);
    check({tag, "_timeout"}, timeout, e.to);
    check({tag, "_err_any"}, err_any, e.ea);
    @(negedge clk16);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_off"}, busy, 0);
    $display("poll %s: lat=%0d status=%h crate=%h fe=%b ce=%b to=%b ea=%b",
             tag, e.lat, status, crate_rx, frame_err, crate_err, timeout, err_any);
  endtask

  initial begin
    init_n    = 1'b0;
    req       = 1'b0;
    exp_crate = 5'h00;
    bytin     = 10'h000;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk16);
    init_n = 1'b1;
    repeat (2) @(negedge clk16);

    // Good frame.
    exp_crate = 5'h0A;
    sb.push_back('{5, 16'hC512, 5'h0A, 1'b0, 1'b0, 1'b0, 1'b1});
    poll("good", 10'h1FF, 10'h00A, 10'h3C5, 10'h012, 4);

    // Crate mismatch: status still loaded.
    exp_crate = 5'h03;
    sb.push_back('{5, 16'h00FF, 5'h05, 1'b0, 1'b1, 1'b0, 1'b0});
    poll("crate", 10'h1FF, 10'h005, 10'h300, 10'h0FF, 4);

    // Bad tag in the status-high slot.
    sb.push_back('{4, 16'h00FF, 5'h05, 1'b1, 1'b0, 1'b0, 1'b0});
    poll("badtag", 10'h1FF, 10'h00A, 10'h0C5, 10'h000, 3);

    // Repeated header in the crate slot.
    sb.push_back('{3, 16'h00FF, 5'h05, 1'b1, 1'b0, 1'b0, 1'b0});
    poll("dblhdr", 10'h1FF, 10'h1FF, 10'h000, 10'h000, 2);

    // Timeout with an idle bus.
    sb.push_back('{65, 16'h00FF, 5'h05, 1'b0, 1'b0, 1'b1, 1'b0});
    poll("timeout", 10'h000, 10'h000, 10'h000, 10'h000, 0);

    // Unsolicited header while idle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk16);
      check("unsol_done", done, 0);
      check("unsol_busy", busy, 0);
      check("unsol_rd", rd, 0);
      bytin = 10'h1FF;
    end
    @(negedge clk16);
    check("unsol_done", done, 0);
    check("unsol_busy", busy, 0);
    bytin = 10'h000;
    $display("unsolicited header: busy=%b done=%b", busy, done);

    // Second req while busy, then reset in W_STHI.
    @(negedge clk16) req = 1'b1;
    @(negedge clk16) req = 1'b0;
    check("rst_rd_strobe", rd, 1);
    @(negedge clk16);
    check("rst_rd_low", rd, 0);
    bytin = 10'h1FF;
    req   = 1'b1;
    @(negedge clk16);
    check("rst_rd_low", rd, 0);
    bytin = 10'h00A;
    req   = 1'b0;
    @(negedge clk16);
    check("rst_no_rd2", rd, 0);
    check("rst_busy_pre", busy, 1);
    bytin  = 10'h3C5;
    init_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk16);
    init_n = 1'b1;
    bytin  = 10'h000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk16);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    $display("mid-frame reset: outputs cleared, no done");

    // First poll after reset.
    exp_crate = 5'h0A;
    sb.push_back('{5, 16'hF034, 5'h0A, 1'b0, 1'b0, 1'b0, 1'b1});
    poll("afterrst", 10'h1FF, 10'h00A, 10'h3F0, 10'h034, 4);

    check("sb_empty", 16'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
